vedic_mul_arbiter: RTL and testbench
====================================

// Module: vedic_mul_arbiter
// PURPOSE
//   Shares one vedic8x8 unsigned 8x8 multiplier among NUM_REQ requesters.
//   Round-robin arbitration; valid/ready handshake on each request port and on
//   the single result port. Two-stage elastic pipeline: operand register, then
//   multiplier, then result register. Sits between client blocks and the datapath.
// PARAMETERS
//   NUM_REQ   4    number of requester ports, 2..8
//   ID_W      2    width of res_id; must equal clog2(NUM_REQ)
//   CNT_W     16   width of the completed-operation counter
// PORTS
//   clk        in   1            rising-edge clock, single clock domain
//   rst_n      in   1            asynchronous active-low reset
//   req_valid  in   NUM_REQ      per-requester operand valid
//   req_a      in   NUM_REQ*8    flat operand A; requester i uses [8*i+7:8*i]
//   req_b      in   NUM_REQ*8    flat operand B; same packing as req_a
//   req_ready  out  NUM_REQ      per-requester accept; at most one bit set (one-hot)
//   res_valid  out  1            result valid
//   res_p      out  16           unsigned product a*b
//   res_id     out  ID_W         index of the requester that owns res_p
//   res_ready  in   1            result consumer ready
//   busy       out  1            any stage holds an operation
//   done_cnt   out  CNT_W        completed results; wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset: the reset is asynchronous, active-low.
//     res_valid=0, res_p=0, res_id=0, busy=0, done_cnt=0.
//     Internal s1_valid=0 and s2_valid=0; rr_ptr=NUM_REQ-1, so requester 0 wins first.
//   Elastic control:
//     s2_rdy = !s2_valid | res_ready
//     s1_rdy = !s1_valid | s2_rdy
//   Arbitration (combinational):
//     - Search req_valid starting at index rr_ptr+1 (mod NUM_REQ); the first set bit wins.
//     - req_ready[g] = s1_rdy & req_valid[g]; all other req_ready bits are 0.
//     - No request pending -> req_ready = 0.
//   Request handshake (req_valid[g] & req_ready[g]):
//     - Latch req_a/req_b slices into s1_a/s1_b, g into s1_id, set s1_valid.
//     - Set rr_ptr <= g.
//     - rr_ptr is unchanged in any cycle without a handshake.
//   Stage advance:
//     - If s2_rdy: s2 <= {s1_valid, s1_id, vedic8x8(s1_a,s1_b)}.
//     - If s1 advances without a new grant, s1_valid <= 0.
//   Outputs: res_valid=s2_valid, res_p=s2_p, res_id=s2_id, all registered.
//   Latency: accept at edge N -> res_valid visible after edge N+1, i.e. 2 cycles.
//   Throughput: 1 op/cycle while res_ready=1.
//   Backpressure: res_valid=1 & res_ready=0 holds res_p and res_id stable.
//     s1 still fills, so at most 2 ops are in flight. After that, req_ready=0.
//   Simultaneous events:
//     - Result handshake and new grant in the same cycle: both occur, no bubble.
//     - done_cnt increments on res_valid & res_ready.
//   Requester rules:
//     - Once req_valid is asserted, it stays high and operands stay stable until req_ready.
//     - Violating this is a protocol error; the block takes no action on it.
//   Arithmetic: unsigned, full 16-bit product, no truncation or rounding.
//   Reset mid-operation: in-flight ops are discarded and produce no result.
//     done_cnt clears; rr_ptr returns to NUM_REQ-1.
//   busy = s1_valid | s2_valid.
// STRUCTURE
//   Shared package/include vedic_pkg:
//     - MUL_W=8, PROD_W=16.
//     - The clog2 helper for ID_W.
//   Sub-module rr_arbiter (NUM_REQ): inputs req, ptr, en; outputs one-hot gnt and encoded idx.
//   Instantiates the existing vedic8x8 unchanged, driven by s1_a and s1_b.
// TESTING
//   1. Single requester 0: a=15, b=10 -> res_p=150, res_id=0, 2 cycles after accept.
//   2. Back-to-back on req 1: 25*12, 50*50, 100*20, 255*255
//      -> 300, 2500, 2000, 65025 on consecutive cycles, done_cnt=4.
//   3. All 4 valid continuously, res_ready=1 -> grant order 0,1,2,3,0,...; res_id follows.
//   4. Hold res_ready=0 for 5 cycles with all valid -> exactly 2 accepts.
//      res_p/res_id stay frozen; req_ready=0 thereafter; release resumes without loss.
//   5. Only reqs 1 and 3 valid after a grant to 3 -> next grant 1, then 3, alternating.
//   6. Assert rst_n=0 with 2 ops in flight -> res_valid=0, busy=0, done_cnt=0.
//      First grant after reset goes to requester 0.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared widths and helpers for the vedic multiplier arbiter slice.
// Holds the crosswise (Urdhva-Tiryagbhyam) 2x2 and 4x4 building blocks.
package vedic_pkg;

    localparam int MUL_W  = 8;
    localparam int PROD_W = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic logic [3:0] vedic2x2(input logic [1:0] a, input logic [1:0] b);
        logic t_lo, t_x1, t_x2, t_hi, t_c;
        t_lo = a[0] & b[0];
        t_x1 = a[1] & b[0];
        t_x2 = a[0] & b[1];
        t_hi = a[1] & b[1];
        t_c  = t_x1 & t_x2;
        return {t_hi & t_c, t_hi ^ t_c, t_x1 ^ t_x2, t_lo};
    endfunction

    function automatic logic [7:0] vedic4x4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p_ll, p_lh, p_hl, p_hh;
        p_ll = vedic2x2(a[1:0], b[1:0]);
        p_lh = vedic2x2(a[1:0], b[3:2]);
        p_hl = vedic2x2(a[3:2], b[1:0]);
        p_hh = vedic2x2(a[3:2], b[3:2]);
        return 8'(p_ll) + (8'(p_lh) << 2) + (8'(p_hl) << 2) + (8'(p_hh) << 4);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts one past ptr, first set req wins.
// gnt is one-hot and gated by en; idx is the winner whenever any req is set.
module rr_arbiter
    import vedic_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic w_found;
    int   w_j;

    always_comb begin
        w_found = 1'b0;
        w_j     = 0;
        idx     = '0;
        gnt     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_j = int'(ptr) + k;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (!w_found && req[w_j]) begin
                w_found = 1'b1;
                idx     = IDX_W'(w_j);
            end
        end
        if (en && w_found) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/vedic8x8.sv
// Unsigned 8x8 combinational multiplier composed from four vedic 4x4 partials.
module vedic8x8
    import vedic_pkg::*;
(
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic [PROD_W-1:0] p
);

    logic [7:0] w_ll;
    logic [7:0] w_lh;
    logic [7:0] w_hl;
    logic [7:0] w_hh;

    assign w_ll = vedic4x4(a[3:0], b[3:0]);
    assign w_lh = vedic4x4(a[3:0], b[7:4]);
    assign w_hl = vedic4x4(a[7:4], b[3:0]);
    assign w_hh = vedic4x4(a[7:4], b[7:4]);

    assign p = 16'(w_ll) + (16'(w_lh) << 4) + (16'(w_hl) << 4) + (16'(w_hh) << 8);

endmodule

// File: rtl/vedic_mul_arbiter.sv
// Round-robin shared vedic 8x8 multiplier: operand stage s1, multiplier, result stage s2.
// All ports are valid/ready: a transfer happens on a clock edge where both valid and ready are high.
module vedic_mul_arbiter
    import vedic_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*MUL_W-1:0] req_a,
    input  logic [NUM_REQ*MUL_W-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     res_valid,
    output logic [PROD_W-1:0]        res_p,
    output logic [ID_W-1:0]          res_id,
    input  logic                     res_ready,
    output logic                     busy,
    output logic [CNT_W-1:0]         done_cnt
);

    logic              r_s1_valid;
    logic [MUL_W-1:0]  r_s1_a;
    logic [MUL_W-1:0]  r_s1_b;
    logic [ID_W-1:0]   r_s1_id;
    logic              r_s2_valid;
    logic [PROD_W-1:0] r_s2_p;
    logic [ID_W-1:0]   r_s2_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_done_cnt;

    logic              w_s1_rdy;
    logic              w_s2_rdy;
    logic              w_accept;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]   w_idx;
    logic [MUL_W-1:0]  w_sel_a;
    logic [MUL_W-1:0]  w_sel_b;
    logic [PROD_W-1:0] w_prod;

    // A stage may take new data when empty or when its content leaves this cycle.
    assign w_s2_rdy = !r_s2_valid || res_ready;
    assign w_s1_rdy = !r_s1_valid || w_s2_rdy;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .req (req_valid),
        .ptr (r_rr_ptr),
        .en  (w_s1_rdy),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    assign req_ready = w_gnt;
    assign w_accept  = |w_gnt;
    assign w_sel_a   = req_a[int'(w_idx)*MUL_W +: MUL_W];
    assign w_sel_b   = req_b[int'(w_idx)*MUL_W +: MUL_W];

    vedic8x8 u_mul (
        .a (r_s1_a),
        .b (r_s1_b),
        .p (w_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_p     <= '0;
            r_s2_id    <= '0;
            r_rr_ptr   <= ID_W'(NUM_REQ - 1);
            r_done_cnt <= '0;
        end else begin
            if (w_s2_rdy) begin
                r_s2_valid <= r_s1_valid;
                r_s2_id    <= r_s1_id;
                r_s2_p     <= w_prod;
            end
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= w_sel_a;
                r_s1_b     <= w_sel_b;
                r_s1_id    <= w_idx;
                r_rr_ptr   <= w_idx;
            end else if (w_s2_rdy) begin
                r_s1_valid <= 1'b0;
            end
            if (r_s2_valid && res_ready) begin
                r_done_cnt <= r_done_cnt + CNT_W'(1);
            end
        end
    end

    assign res_valid = r_s2_valid;
    assign res_p     = r_s2_p;
    assign res_id    = r_s2_id;
    assign busy      = r_s1_valid || r_s2_valid;
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Bench for vedic_mul_arbiter: directed scenarios plus random traffic against a
// transaction-level model (in-flight queue of at most two products, round-robin winner).
module tb_vedic_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 16;
    localparam int EW      = 32 + ID_W + 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ*8-1:0] req_a = '0;
    logic [NUM_REQ*8-1:0] req_b = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 res_valid;
    logic [15:0]          res_p;
    logic [ID_W-1:0]      res_id;
    logic                 res_ready = 1'b0;
    logic                 busy;
    logic [CNT_W-1:0]     done_cnt;

    vedic_mul_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_p     (res_p),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: each entry is {accept_edge, id, product}, oldest first.
    logic [EW-1:0] exp_q[$];
    int            grant_log[$];
    int            res_log[$];
    int            res_cyc[$];
    int            m_last = NUM_REQ - 1;
    int            m_done = 0;
    bit            prev_hold = 1'b0;
    logic [15:0]   prev_p;
    logic [ID_W-1:0] prev_id;

    int              win;
    int              g;
    logic [NUM_REQ-1:0] exp_rdy;
    bit              room;
    bit              exp_vis;
    logic [EW-1:0]   front;
    logic [15:0]     prod;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_last    = NUM_REQ - 1;
            m_done    = 0;
            prev_hold = 1'b0;
        end else begin
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            front   = (exp_q.size() > 0) ? exp_q[0] : '0;
            exp_vis = (exp_q.size() > 0) && (cyc >= int'(front[EW-1:18]) + 1);
            check("res_valid", 32'(res_valid), 32'(exp_vis));
            if (res_valid && exp_q.size() > 0) begin
                check("res_p", 32'(res_p), 32'(front[15:0]));
                check("res_id", 32'(res_id), 32'(front[17:16]));
            end
            if (prev_hold) begin
                check("hold_p", 32'(res_p), 32'(prev_p));
                check("hold_id", 32'(res_id), 32'(prev_id));
            end
            check("done_cnt", 32'(done_cnt), 32'(m_done % 65536));

            // Two ops in flight fill both slots; only a draining result frees one.
            room = !(exp_q.size() >= 2 && !res_ready);
            win  = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (win < 0 && req_valid[(m_last + k) % NUM_REQ]) win = (m_last + k) % NUM_REQ;
            end
            exp_rdy = (room && win >= 0) ? NUM_REQ'(1 << win) : '0;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));

            if (res_valid && res_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                m_done++;
                res_log.push_back(int'(res_p));
                res_cyc.push_back(cyc);
            end
            if ((req_valid & req_ready) != '0) begin
                g = 0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) g = i;
                end
                prod = 16'(int'(req_a[8*g +: 8]) * int'(req_b[8*g +: 8]));
                exp_q.push_back({32'(cyc + 1), ID_W'(g), prod});
                m_last = g;
                grant_log.push_back(g);
            end
            prev_hold = res_valid && !res_ready;
            prev_p    = res_p;
            prev_id   = res_id;
        end
    end

    function automatic logic [7:0] pick_operand();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 8'd0;
        if (r == 1) return 8'd255;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        grant_log.delete();
        res_log.delete();
        res_cyc.delete();
    endtask

    // One cycle of requester behaviour: a request is only changed once it has been
    // accepted (or was idle); keep selects which requesters raise valid.
    task automatic step(input logic [NUM_REQ-1:0] keep, input bit rnd);
        logic [NUM_REQ-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i] || !req_valid[i]) begin
                req_valid[i]    = rnd ? ($urandom_range(0, 2) != 0) : keep[i];
                req_a[8*i +: 8] = pick_operand();
                req_b[8*i +: 8] = pick_operand();
            end
        end
        if (rnd) res_ready = ($urandom_range(0, 3) != 0);
    endtask

    int ta[4] = '{25, 50, 100, 255};
    int tb[4] = '{12, 50, 20, 255};
    int tp[4] = '{300, 2500, 2000, 65025};
    int exp_order5[5] = '{3, 1, 3, 1, 3};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        #3;
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_p", 32'(res_p), 0);
        check("rst_res_id", 32'(res_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done_cnt", 32'(done_cnt), 0);

        // Single request, two-cycle latency
        do_reset();
        res_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0001;
        req_a[7:0] = 8'd15;
        req_b[7:0] = 8'd10;
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("t1_not_yet", 32'(res_valid), 0);
        @(negedge clk);
        check("t1_valid", 32'(res_valid), 1);
        check("t1_p", 32'(res_p), 150);
        check("t1_id", 32'(res_id), 0);

        // Back-to-back on requester 1
        do_reset();
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            req_valid = 4'b0010;
            req_a[15:8] = 8'(ta[k]);
            req_b[15:8] = 8'(tb[k]);
            @(negedge clk);
            check("t2_ready", 32'(req_ready), 32'b0010);
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        check("t2_count", 32'(res_log.size()), 4);
        for (int k = 0; k < res_log.size() && k < 4; k++) begin
            check("t2_p", 32'(res_log[k]), 32'(tp[k]));
            check("t2_consec", 32'(res_cyc[k] - res_cyc[0]), 32'(k));
        end
        check("t2_done_cnt", 32'(done_cnt), 4);

        // All requesters valid: strict rotation from 0
        do_reset();
        res_ready = 1'b1;
        repeat (12) step(4'b1111, 1'b0);
        check("t3_grants", 32'(grant_log.size() >= 8), 1);
        for (int k = 0; k < grant_log.size() && k < 8; k++) begin
            check("t3_order", 32'(grant_log[k]), 32'(k % NUM_REQ));
        end
        repeat (6) step(4'b0000, 1'b0);

        // Backpressure: two accepts, then stall, then resume without loss
        do_reset();
        res_ready = 1'b0;
        repeat (6) step(4'b1111, 1'b0);
        @(negedge clk);
        check("t4_accepts", 32'(grant_log.size()), 2);
        check("t4_ready_off", 32'(req_ready), 0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        repeat (10) step(4'b1111, 1'b0);
        repeat (8) step(4'b0000, 1'b0);
        check("t4_no_loss", 32'(res_log.size()), 32'(grant_log.size()));

        // Requesters 1 and 3 alternate after a grant to 3
        do_reset();
        res_ready = 1'b1;
        step(4'b1000, 1'b0);
        repeat (8) step(4'b1010, 1'b0);
        for (int k = 0; k < grant_log.size() && k < 5; k++) begin
            check("t5_order", 32'(grant_log[k]), 32'(exp_order5[k]));
        end
        check("t5_grants", 32'(grant_log.size() >= 5), 1);
        repeat (6) step(4'b0000, 1'b0);

        // Random traffic with random backpressure
        do_reset();
        repeat (1500) step(4'b0000, 1'b1);
        res_ready = 1'b1;
        repeat (10) step(4'b0000, 1'b0);
        check("rand_no_loss", 32'(res_log.size()), 32'(grant_log.size()));

        // Reset with two ops in flight
        res_ready = 1'b0;
        repeat (4) step(4'b1111, 1'b0);
        @(negedge clk);
        check("t6_busy_pre", 32'(busy), 1);
        check("t6_valid_pre", 32'(res_valid), 1);
        check("t6_done_pre", 32'(done_cnt != 0), 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("t6_res_valid", 32'(res_valid), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_done_cnt", 32'(done_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        grant_log.delete();
        res_ready = 1'b1;
        @(negedge clk);
        check("t6_first_grant", 32'(req_ready), 32'b0001);
        repeat (10) step(4'b0000, 1'b0);
        check("t6_first_logged", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 0);

        check("end_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
